// File: rtl/stage_write_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_write_seq_if
// Description : Retire handshake and register-file write port bundle.
// Revision    : 1.0
// ============================================================================
interface stage_write_seq_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       insn;
    logic [DATA_W-1:0] o_in;
    logic [DATA_W-1:0] d_in;
    logic              write_exception;
    logic [DATA_W-1:0] status_code;
    logic [DATA_W-1:0] data_writeReg;
    logic [REG_AW-1:0] ctrl_writeReg;
    logic              ctrl_writeEnable;
    logic              busy;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        output in_valid, insn, o_in, d_in, write_exception, status_code,
        input  in_ready, data_writeReg, ctrl_writeReg, ctrl_writeEnable, busy, retired_count
    );

    modport slave (
        input  in_valid, insn, o_in, d_in, write_exception, status_code,
        output in_ready, data_writeReg, ctrl_writeReg, ctrl_writeEnable, busy, retired_count
    );
endinterface
`default_nettype wire

// File: rtl/stage_write_seq.sv
`default_nettype none
// ============================================================================
// Module      : stage_write_seq
// Description : Registered writeback stage with optional dual-write exceptions.
// Revision    : 1.0
// ============================================================================
module stage_write_seq #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int STATUS_REG = 30,
    parameter int LINK_REG   = 31,
    parameter int DUAL_WRITE = 1,
    parameter int CNT_W      = 32
) (
    input  wire logic         clock,
    input  wire logic         reset,
    stage_write_seq_if.slave  bus
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [REG_AW-1:0] STATUS_ADDR = REG_AW'(STATUS_REG);
    localparam logic [REG_AW-1:0] LINK_ADDR   = REG_AW'(LINK_REG);
    localparam logic              DUAL_EN     = (DUAL_WRITE != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRI  = 2'd1,
        SEC  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sec_pending_q, sec_pending_d;
    logic [DATA_W-1:0] sec_data_q, sec_data_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [4:0]        opcode;
    logic [4:0]        alu_op;
    logic [REG_AW-1:0] rd;
    logic              exc_capable;
    logic              exc;
    logic              pri_has_write;
    logic [REG_AW-1:0] pri_addr;
    logic [DATA_W-1:0] pri_data;
    logic              ready;
    logic              accept;
    logic              retiring;
    logic              unused_insn_bits;

    assign opcode           = bus.insn[31:27];
    assign alu_op           = bus.insn[6:2];
    assign rd               = REG_AW'(bus.insn[26:22]);
    assign unused_insn_bits = ^{bus.insn[21:7], bus.insn[1:0]};

    assign exc_capable = (opcode == OP_ADDI) ||
                         ((opcode == OP_RTYPE) &&
                          ((alu_op == ALU_ADD) || (alu_op == ALU_SUB) ||
                           (alu_op == ALU_MUL) || (alu_op == ALU_DIV)));
    assign exc         = bus.write_exception & exc_capable;

    // Primary write target; in single-write mode an exception replaces it.
    always_comb begin
        pri_has_write = 1'b1;
        pri_addr      = rd;
        pri_data      = bus.o_in;
        case (opcode)
            OP_RTYPE, OP_ADDI: ;
            OP_LW:             pri_data = bus.d_in;
            OP_JAL:            pri_addr = LINK_ADDR;
            OP_SETX:           pri_addr = STATUS_ADDR;
            default:           pri_has_write = 1'b0;
        endcase
        if (exc && !DUAL_EN) begin
            pri_has_write = 1'b1;
            pri_addr      = STATUS_ADDR;
            pri_data      = bus.status_code;
        end
    end

    assign ready    = !((state_q == PRI) && sec_pending_q);
    assign accept   = bus.in_valid & ready;
    assign retiring = ((state_q == PRI) && !sec_pending_q) || (state_q == SEC);

    always_comb begin
        state_d       = state_q;
        sec_pending_d = sec_pending_q;
        sec_data_d    = sec_data_q;
        we_d          = 1'b0;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        cnt_d         = retiring ? cnt_q + CNT_W'(1) : cnt_q;

        if (accept) begin
            state_d       = PRI;
            sec_pending_d = exc & DUAL_EN;
            sec_data_d    = bus.status_code;
            if (pri_has_write) begin
                waddr_d = pri_addr;
                wdata_d = pri_data;
                we_d    = (pri_addr != '0);
            end
        end else if ((state_q == PRI) && sec_pending_q) begin
            state_d       = SEC;
            sec_pending_d = 1'b0;
            waddr_d       = STATUS_ADDR;
            wdata_d       = sec_data_q;
            we_d          = (STATUS_ADDR != '0);
        end else begin
            state_d       = IDLE;
            sec_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            sec_pending_q <= 1'b0;
            sec_data_q    <= '0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            sec_pending_q <= sec_pending_d;
            sec_data_q    <= sec_data_d;
            we_q          <= we_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.in_ready         = ready;
    assign bus.busy             = !ready;
    assign bus.data_writeReg    = wdata_q;
    assign bus.ctrl_writeReg    = waddr_q;
    assign bus.ctrl_writeEnable = we_q;
    assign bus.retired_count    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_write_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_write_seq
// Description : Directed plus random bench for both DUAL_WRITE settings.
// Revision    : 1.0
// ============================================================================
module tb_stage_write_seq;

    logic clk;
    logic rst;

    logic        v_valid;
    logic [31:0] v_insn;
    logic [31:0] v_o;
    logic [31:0] v_d;
    logic        v_exc;
    logic [31:0] v_sc;

    stage_write_seq_if #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) bus0 ();
    stage_write_seq_if #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) bus1 ();

    assign bus0.in_valid = v_valid;  assign bus1.in_valid = v_valid;
    assign bus0.insn     = v_insn;   assign bus1.insn     = v_insn;
    assign bus0.o_in     = v_o;      assign bus1.o_in     = v_o;
    assign bus0.d_in     = v_d;      assign bus1.d_in     = v_d;
    assign bus0.write_exception = v_exc;
    assign bus1.write_exception = v_exc;
    assign bus0.status_code = v_sc;  assign bus1.status_code = v_sc;

    stage_write_seq #(.DUAL_WRITE(0)) dut0 (.clock(clk), .reset(rst), .bus(bus0));
    stage_write_seq #(.DUAL_WRITE(1)) dut1 (.clock(clk), .reset(rst), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One register-file write (or write-free retire slot) as seen on the outputs.
    typedef struct {
        logic        chk;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    wr_t         cur [2];
    wr_t         pend[2];
    logic        pend_v[2];
    logic [31:0] cnt[2];

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] alu);
        logic [14:0] mid;
        logic [1:0]  lo;
        mid = 15'($urandom);
        lo  = 2'($urandom);
        return {op, rd, mid, alu, lo};
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s dut%0d obs=%h exp=%h", tag, d, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk("in_ready", d, 32'(d == 1 ? bus1.in_ready : bus0.in_ready), 32'(!pend_v[d]));
            chk("busy", d, 32'(d == 1 ? bus1.busy : bus0.busy), 32'(pend_v[d]));
            chk("we", d, 32'(d == 1 ? bus1.ctrl_writeEnable : bus0.ctrl_writeEnable), 32'(cur[d].we));
            chk("count", d, d == 1 ? bus1.retired_count : bus0.retired_count, cnt[d]);
            if (cur[d].chk) begin
                chk("addr", d, 32'(d == 1 ? bus1.ctrl_writeReg : bus0.ctrl_writeReg), 32'(cur[d].addr));
                chk("data", d, d == 1 ? bus1.data_writeReg : bus0.data_writeReg, cur[d].data);
            end
        end
    endtask

    function automatic wr_t mkwr(input logic has, input logic [4:0] a, input logic [31:0] dt, input logic last);
        wr_t w;
        w.chk  = has;
        w.we   = has && (a != 5'd0);
        w.addr = a;
        w.data = dt;
        w.last = last;
        return w;
    endfunction

    // Reference behaviour for one clock edge of DUT d.
    task automatic model_edge(input int d);
        logic [4:0] op, rd, alu;
        logic       capable, exc;
        if (rst) begin
            pend_v[d] = 1'b0;
            cur[d]    = mkwr(1'b1, 5'd0, 32'd0, 1'b0);
            cur[d].we = 1'b0;
            cnt[d]    = 32'd0;
            return;
        end
        if (cur[d].last) cnt[d] = cnt[d] + 32'd1;
        if (v_valid && !pend_v[d]) begin
            op  = v_insn[31:27];
            rd  = v_insn[26:22];
            alu = v_insn[6:2];
            capable = (op == 5'b00101) ||
                      (op == 5'b00000 && (alu == 5'd0 || alu == 5'd1 || alu == 5'd6 || alu == 5'd7));
            exc = v_exc && capable;
            if (exc && d == 1) begin
                cur[d]    = mkwr(1'b1, rd, v_o, 1'b0);
                pend[d]   = mkwr(1'b1, 5'd30, v_sc, 1'b1);
                pend_v[d] = 1'b1;
            end else if (exc) begin
                cur[d] = mkwr(1'b1, 5'd30, v_sc, 1'b1);
            end else begin
                case (op)
                    5'b00000, 5'b00101: cur[d] = mkwr(1'b1, rd, v_o, 1'b1);
                    5'b01000:           cur[d] = mkwr(1'b1, rd, v_d, 1'b1);
                    5'b00011:           cur[d] = mkwr(1'b1, 5'd31, v_o, 1'b1);
                    5'b10101:           cur[d] = mkwr(1'b1, 5'd30, v_o, 1'b1);
                    default:            cur[d] = mkwr(1'b0, 5'd0, 32'd0, 1'b1);
                endcase
            end
        end else if (pend_v[d]) begin
            cur[d]    = pend[d];
            pend_v[d] = 1'b0;
        end else begin
            cur[d] = mkwr(1'b0, 5'd0, 32'd0, 1'b0);
        end
    endtask

    // Called at a falling edge: check, drive, advance the model, wait a cycle.
    task automatic step(input logic r, input logic vld, input logic [31:0] ins, input logic [31:0] o,
                        input logic [31:0] dd, input logic wx, input logic [31:0] sc);
        check_all();
        rst = r; v_valid = vld; v_insn = ins; v_o = o; v_d = dd; v_exc = wx; v_sc = sc;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    logic [4:0]  r_op, r_alu, r_rd;
    logic [4:0]  ops[6];
    logic [4:0]  alus[5];

    initial begin
        ops  = '{5'b00000, 5'b00101, 5'b01000, 5'b00011, 5'b10101, 5'b00010};
        alus = '{5'd0, 5'd1, 5'd6, 5'd7, 5'd2};
        rst = 1'b1; v_valid = 1'b0; v_insn = 32'd0; v_o = 32'd0; v_d = 32'd0; v_exc = 1'b0; v_sc = 32'd0;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        step(1'b1, 1'b1, mk(5'b01000, 5'd9, 5'd0), 32'h1, 32'h2, 1'b0, 32'h3);

        // lw rd=5
        step(1'b0, 1'b1, mk(5'b01000, 5'd5, 5'd0), 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0);
        idle();
        idle();
        // add rd=3 with exception, valid held for two cycles
        step(1'b0, 1'b1, mk(5'b00000, 5'd3, 5'd0), 32'd7, 32'd0, 1'b1, 32'd1);
        step(1'b0, 1'b1, mk(5'b00000, 5'd3, 5'd0), 32'd7, 32'd0, 1'b1, 32'd1);
        idle();
        idle();
        // jal then setx back-to-back
        step(1'b0, 1'b1, mk(5'b00011, 5'd4, 5'd0), 32'h40, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b1, mk(5'b10101, 5'd4, 5'd0), 32'h99, 32'd0, 1'b0, 32'd0);
        idle();
        idle();
        // addi to r0, bne-class, lw with a stray exception flag
        step(1'b0, 1'b1, mk(5'b00101, 5'd0, 5'd0), 32'h11, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b1, mk(5'b00010, 5'd6, 5'd0), 32'h22, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b1, mk(5'b01000, 5'd7, 5'd0), 32'h33, 32'h44, 1'b1, 32'h55);
        idle();
        idle();
        // dual-write exception interrupted by reset during PRI
        step(1'b0, 1'b1, mk(5'b00101, 5'd8, 5'd0), 32'h66, 32'd0, 1'b1, 32'h77);
        step(1'b1, 1'b1, mk(5'b00101, 5'd8, 5'd0), 32'h66, 32'd0, 1'b1, 32'h77);
        idle();

        for (int i = 0; i < 600; i++) begin
            r_op  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 5)];
            r_alu = ($urandom_range(0, 3) == 0) ? 5'($urandom) : alus[$urandom_range(0, 4)];
            r_rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 63) == 0, $urandom_range(0, 4) != 0, mk(r_op, r_rd, r_alu),
                 $urandom, $urandom, $urandom_range(0, 2) == 0, $urandom);
        end
        idle();
        idle();
        check_all();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
